// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready back-pressure and flush.
// Define DFF_PIPE_COUNT_EN to add the registered occupancy_o output.
module dff_pipe #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    output logic [WIDTH-1:0]           out_data_o,
`ifdef DFF_PIPE_COUNT_EN
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
`endif
    input  logic                       out_ready_i
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             push;
    logic             pop;

    // A stage can move when it is empty or every stage below it can move.
    always_comb begin
        logic acc;
        acc = out_ready_i;
        rdy = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc    = acc | ~valid_q[k];
            rdy[k] = acc;
        end
    end

    assign in_ready_o  = rdy[0] & ~flush_i & reset_i;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = valid_q[DEPTH-1] & out_ready_i;
    assign out_valid_o = valid_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            if (rdy[0]) begin
                valid_d[0] = push;
                if (push) begin
                    data_d[0] = in_data_i;
                end
            end
            // Empty stages load too, which is what compacts bubbles.
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = data_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= RESET_VALUE;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`ifdef DFF_PIPE_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy_o = occ_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5).
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_dff_pipe;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
`ifdef DFF_PIPE_COUNT_EN
    logic [1:0] occupancy;
`endif

    int tests = 0;
    int fails = 0;

    dff_pipe #(
        .WIDTH      (8),
        .DEPTH      (3),
        .RESET_VALUE(8'hA5)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
`ifdef DFF_PIPE_COUNT_EN
        .occupancy_o(occupancy),
`endif
        .out_ready_i(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #1 reset  = 1'b0;

        // Reset held for three clocks
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'hA5);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef DFF_PIPE_COUNT_EN
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
`endif
        reset = 1'b1;
        tick();
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_out_valid", {31'd0, out_valid}, 32'd0);

        // Streaming 01..08, word w visible after edge w+2
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk("stream_valid", {31'd0, out_valid}, (c >= 3 && c <= 10) ? 32'd1 : 32'd0);
            if (c >= 3 && c <= 10) begin
                chk("stream_data", {24'd0, out_data}, 32'(c - 2));
            end
            in_valid = (c + 1 <= 8);
            in_data  = 8'(c + 1);
        end

        // Back-pressure: only three words fit while stalled
        out_ready = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            in_valid = 1'b1;
            in_data  = 8'(w);
            #1 chk("bp_accept", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_data = 8'h04;
        #1;
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_full_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_full_data", {24'd0, out_data}, 32'h01);
`ifdef DFF_PIPE_COUNT_EN
        chk("bp_occ", {30'd0, occupancy}, 32'd3);
`endif
        tick();
        tick();
        chk("bp_hold_data", {24'd0, out_data}, 32'h01);
        chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1 chk("bp_ready_prop", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_out2", {24'd0, out_data}, 32'h02);
`ifdef DFF_PIPE_COUNT_EN
        chk("bp_occ_pushpop", {30'd0, occupancy}, 32'd3);
`endif
        in_data = 8'h05;
        tick();
        chk("bp_out3", {24'd0, out_data}, 32'h03);
        in_valid = 1'b0;
        tick();
        chk("bp_out4", {24'd0, out_data}, 32'h04);
        chk("bp_out4_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_out5", {24'd0, out_data}, 32'h05);
        chk("bp_out5_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 8'h22;
        #1 chk("bub_accept", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("bub_valid", {31'd0, out_valid}, 32'd1);
        chk("bub_head", {24'd0, out_data}, 32'h11);
        chk("bub_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DFF_PIPE_COUNT_EN
        chk("bub_occ", {30'd0, occupancy}, 32'd2);
`endif
        out_ready = 1'b1;
        tick();
        chk("bub_second_valid", {31'd0, out_valid}, 32'd1);
        chk("bub_second", {24'd0, out_data}, 32'h22);
        tick();
        chk("bub_drained", {31'd0, out_valid}, 32'd0);

        // Flush with a full pipeline
        out_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + w);
            tick();
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fl_pre_valid", {31'd0, out_valid}, 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_data_kept", {24'd0, out_data}, 32'h31);
`ifdef DFF_PIPE_COUNT_EN
        chk("fl_occ", {30'd0, occupancy}, 32'd0);
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h42;
        for (int c = 1; c <= 4; c++) begin
            tick();
            in_valid = 1'b0;
            chk("fl_post_valid", {31'd0, out_valid}, (c == 3) ? 32'd1 : 32'd0);
            if (c == 3) begin
                chk("fl_post_data", {24'd0, out_data}, 32'h42);
            end
        end

        // Async reset between edges with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h51;
        tick();
        in_data = 8'h52;
        tick();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_data", {24'd0, out_data}, 32'hA5);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("ar_never_out", {31'd0, out_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
